// File: rtl/guess_game_ctrl.sv
// Game sequencer in front of the guess FSM: step ticks, clear pulses, score/lives/level.
// Define GUESS_GAME_CTRL_DEBOUNCE_EN to add a per-bit debounce after the button synchronizer.
module guess_game_ctrl #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned HOLD_TICKS = 2,
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic       win_in,
  input  logic       lose_in,
  output logic       en_out,
  output logic       fsm_clr,
  output logic [3:0] btn_out,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic [1:0] level,
  output logic       busy,
  output logic       game_over
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, RESULT, OVER} state_e;

  if (TICK_DIV < 8 || HOLD_TICKS < 1 || DEB_CYCLES < 1) begin : g_param_check
    $error("guess_game_ctrl: TICK_DIV must be >= 8, HOLD_TICKS and DEB_CYCLES >= 1");
  end

  state_e        state_q, state_d;
  logic [3:0]    score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [1:0]    level_q, level_d;
  logic [TW-1:0] tick_q, tick_d, tick_term;
  logic [HW-1:0] hold_q, hold_d;
  logic          clr_q, clr_d;
  logic [1:0]    rst_sync_q;
  logic          rst_ni;
  logic [3:0]    sync1_q, sync2_q, btn_cond;
  logic          tick_last, hold_last;

  // Reset asserts immediately but is released to the rest of the block on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_ni = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef GUESS_GAME_CTRL_DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  logic [DW-1:0] deb_cnt_q [4];
  logic [3:0]    deb_q;

  // A bit flips only after disagreeing with its conditioned value for DEB_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end
  assign btn_cond = deb_q;
`else
  assign btn_cond = sync2_q;
`endif

  assign tick_term = TW'((TICK_DIV >> level_q) - 1);
  assign tick_last = (tick_q == tick_term);
  assign hold_last = (hold_q == HW'(HOLD_TICKS - 1));

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      score_q <= '0;
      lives_q <= '0;
      level_q <= '0;
      tick_q  <= '0;
      hold_q  <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      level_q <= level_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    level_d = level_q;
    tick_d  = tick_q;
    hold_d  = hold_q;
    clr_d   = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        tick_d = '0;
        hold_d = '0;
        if (start) begin
          state_d = PLAY;
          score_d = '0;
          lives_d = 2'd3;
          level_d = '0;
          clr_d   = 1'b1;
        end
      end
      PLAY: begin
        tick_d = tick_last ? '0 : tick_q + 1'b1;
        if (win_in) begin
          score_d = (score_q == 4'd15) ? score_q : score_q + 4'd1;
          level_d = (level_q == 2'd3) ? level_q : level_q + 2'd1;
          state_d = RESULT;
          tick_d  = '0;
          hold_d  = '0;
        end else if (lose_in) begin
          lives_d = (lives_q == 2'd0) ? lives_q : lives_q - 2'd1;
          state_d = RESULT;
          tick_d  = '0;
          hold_d  = '0;
        end
      end
      RESULT: begin
        tick_d = tick_last ? '0 : tick_q + 1'b1;
        if (tick_last) begin
          if (hold_last) begin
            hold_d = '0;
            if (lives_q == 2'd0) begin
              state_d = OVER;
            end else begin
              state_d = PLAY;
              clr_d   = 1'b1;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // At the fastest level the terminal count can coincide with the clear cycle; clear wins.
  assign en_out    = (state_q == PLAY) && tick_last && !clr_q;
  assign fsm_clr   = clr_q;
  assign btn_out   = (state_q == PLAY) ? btn_cond : 4'b0000;
  assign score     = score_q;
  assign lives     = lives_q;
  assign level     = level_q;
  assign busy      = (state_q == PLAY) || (state_q == RESULT);
  assign game_over = (state_q == OVER);
endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed self-checking bench for guess_game_ctrl with TICK_DIV=8, HOLD_TICKS=2.
module tb_guess_game_ctrl;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] btn;
  logic       win_in;
  logic       lose_in;
  logic       en_out;
  logic       fsm_clr;
  logic [3:0] btn_out;
  logic [3:0] score;
  logic [1:0] lives;
  logic [1:0] level;
  logic       busy;
  logic       game_over;

  int vectors     = 0;
  int miscompares = 0;
  int expScore;
  int expLevel;
  int expLives;

  guess_game_ctrl #(.TICK_DIV(8), .HOLD_TICKS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .btn       (btn),
    .win_in    (win_in),
    .lose_in   (lose_in),
    .en_out    (en_out),
    .fsm_clr   (fsm_clr),
    .btn_out   (btn_out),
    .score     (score),
    .lives     (lives),
    .level     (level),
    .busy      (busy),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic w, input logic l, input logic [3:0] b);
    start   = s;
    win_in  = w;
    lose_in = l;
    btn     = b;
  endtask

  task automatic nextCycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] allOuts();
    return {16'd0, score, lives, level, busy, game_over, en_out, fsm_clr, btn_out};
  endfunction

  // RESULT lasts two ticks at the current level; 8>>level cycles per tick.
  task automatic holdResult();
    for (int r = 0; r < 2 * (8 >> expLevel); r++) begin
      checkOutput("result_busy", 32'(busy), 1);
      checkOutput("result_en", 32'(en_out), 0);
      checkOutput("result_clr", 32'(fsm_clr), 0);
      nextCycle(1);
    end
  endtask

  task automatic playWin(input logic withLose);
    applyStimulus(1'b0, 1'b1, withLose, 4'b0000);
    nextCycle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    expScore = (expScore < 15) ? expScore + 1 : 15;
    expLevel = (expLevel < 3) ? expLevel + 1 : 3;
    checkOutput("win_score", 32'(score), expScore);
    checkOutput("win_level", 32'(level), expLevel);
    checkOutput("win_lives", 32'(lives), expLives);
    holdResult();
    checkOutput("replay_clr", 32'(fsm_clr), 1);
    checkOutput("replay_en", 32'(en_out), 0);
    checkOutput("replay_busy", 32'(busy), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    rst_n    = 1'b0;
    expScore = 0;
    expLevel = 0;
    expLives = 0;
    nextCycle(3);
    checkOutput("reset_outputs", allOuts(), 32'd0);
    rst_n = 1'b1;
    nextCycle(4);
    checkOutput("idle_outputs", allOuts(), 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0100);
    nextCycle(3);
    checkOutput("idle_btn_out", 32'(btn_out), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000);
    nextCycle(3);
    checkOutput("idle_win_ignored", 32'(score), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);

    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
    nextCycle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    expLives = 3;
    checkOutput("start_clr", 32'(fsm_clr), 1);
    checkOutput("start_en", 32'(en_out), 0);
    checkOutput("start_busy", 32'(busy), 1);
    checkOutput("start_lives", 32'(lives), 3);
    checkOutput("start_score", 32'(score), 0);
    checkOutput("start_level", 32'(level), 0);
    checkOutput("start_over", 32'(game_over), 0);
    for (int k = 1; k <= 16; k++) begin
      nextCycle(1);
      checkOutput("lvl0_en", 32'(en_out), ((k % 8) == 7) ? 1 : 0);
      checkOutput("lvl0_clr", 32'(fsm_clr), 0);
    end

    playWin(1'b0);
    for (int k = 1; k <= 8; k++) begin
      nextCycle(1);
      checkOutput("lvl1_en", 32'(en_out), ((k % 4) == 3) ? 1 : 0);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0100);
    nextCycle(1);
    checkOutput("play_btn_1cyc", 32'(btn_out), 0);
    nextCycle(1);
    checkOutput("play_btn_2cyc", 32'(btn_out), 32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    nextCycle(2);
    checkOutput("play_btn_release", 32'(btn_out), 0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
      nextCycle(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
      expLives--;
      checkOutput("lose_lives", 32'(lives), expLives);
      checkOutput("lose_score", 32'(score), 1);
      checkOutput("lose_level", 32'(level), 1);
      holdResult();
      checkOutput("lose_after_clr", 32'(fsm_clr), (expLives != 0) ? 1 : 0);
      checkOutput("lose_after_over", 32'(game_over), (expLives == 0) ? 1 : 0);
    end
    checkOutput("over_busy", 32'(busy), 0);
    checkOutput("over_lives", 32'(lives), 0);

    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0100);
    nextCycle(3);
    checkOutput("over_btn_out", 32'(btn_out), 0);
    checkOutput("over_win_ignored", 32'(score), 1);
    checkOutput("over_hold", 32'(game_over), 1);

    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0100);
    nextCycle(1);
    expScore = 0;
    expLevel = 0;
    expLives = 3;
    checkOutput("restart_score", 32'(score), 0);
    checkOutput("restart_lives", 32'(lives), 3);
    checkOutput("restart_level", 32'(level), 0);
    checkOutput("restart_clr", 32'(fsm_clr), 1);
    checkOutput("restart_over", 32'(game_over), 0);
    checkOutput("restart_btn_out", 32'(btn_out), 32'h4);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
    nextCycle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("play_start_ignored", 32'(fsm_clr), 0);

    playWin(1'b1);
    for (int w = 0; w < 16; w++) playWin(1'b0);
    checkOutput("sat_score", 32'(score), 15);
    checkOutput("sat_level", 32'(level), 3);
    nextCycle(1);
    checkOutput("lvl3_en", 32'(en_out), 1);
    checkOutput("lvl3_clr", 32'(fsm_clr), 0);

    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
    nextCycle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("pre_reset_busy", 32'(busy), 1);
    checkOutput("pre_reset_score", 32'(score), 15);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", allOuts(), 32'd0);
    nextCycle(2);
    rst_n = 1'b1;
    nextCycle(4);
    checkOutput("post_reset_idle", allOuts(), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
    nextCycle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("post_reset_start", {16'd0, score, lives, level, busy, game_over, en_out, fsm_clr, btn_out},
                {16'd0, 4'd0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
